// File: rtl/exu_mdu.sv
// exu_mdu: iterative RV32M multiply/divide unit (shift-add multiply, restoring divide)
module exu_mdu #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              idex2mdu_start_i,
    input  logic [2:0]        idex2mdu_funct3_i,
    input  logic [XLEN-1:0]   idex2mdu_source1_i,
    input  logic [XLEN-1:0]   idex2mdu_source2_i,
    input  logic [REG_AW-1:0] idex2mdu_rd_addr_i,
    input  logic              cu2mdu_flush_i,
    output logic              mdu2cu_stall_o,
    output logic [REG_AW-1:0] mdu2regs_rd_addr_o,
    output logic [XLEN-1:0]   mdu2regs_rd_data_o,
    output logic              mdu2regs_wb_en_o,
    output logic              mdu_busy_o
);
    localparam int CW = $clog2(XLEN) + 1;
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t state, state_nxt;
    logic [CW-1:0] cnt;
    logic [2:0] f3;
    logic [XLEN-1:0] op_b, a_mag, b_mag, fast_res, q, r, res;
    logic [2*XLEN-1:0] acc, acc_nxt, prod;
    logic [XLEN:0] msum, rtrial;
    logic neg_q, neg_r, go, s1_sgn, s2_sgn, div_zero, div_ovf, fast, ge;
    assign go       = idex2mdu_start_i & ~cu2mdu_flush_i;
    assign s1_sgn   = idex2mdu_source1_i[XLEN-1] & (idex2mdu_funct3_i[2] ? ~idex2mdu_funct3_i[0]
                                                   : idex2mdu_funct3_i[0] ^ idex2mdu_funct3_i[1]);
    assign s2_sgn   = idex2mdu_source2_i[XLEN-1] & (idex2mdu_funct3_i[2] ? ~idex2mdu_funct3_i[0]
                                                   : idex2mdu_funct3_i == 3'b001);
    assign a_mag    = s1_sgn ? -idex2mdu_source1_i : idex2mdu_source1_i;
    assign b_mag    = s2_sgn ? -idex2mdu_source2_i : idex2mdu_source2_i;
    assign div_zero = idex2mdu_funct3_i[2] & (idex2mdu_source2_i == '0);
    assign div_ovf  = idex2mdu_funct3_i[2] & ~idex2mdu_funct3_i[0] & (&idex2mdu_source2_i)
                    & (idex2mdu_source1_i == {1'b1, {(XLEN-1){1'b0}}});
    assign fast     = div_zero | div_ovf;
    assign fast_res = div_zero ? (idex2mdu_funct3_i[1] ? idex2mdu_source1_i : '1)
                               : (idex2mdu_funct3_i[1] ? '0 : idex2mdu_source1_i);
    // acc holds {partial product, multiplier} or {partial remainder, dividend/quotient}
    assign msum    = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, op_b} : '0);
    assign ge      = acc[2*XLEN-1:XLEN-1] >= {1'b0, op_b};
    assign rtrial  = acc[2*XLEN-1:XLEN-1] - {1'b0, op_b};
    assign acc_nxt = f3[2] ? {ge ? rtrial[XLEN-1:0] : acc[2*XLEN-2:XLEN-1], acc[XLEN-2:0], ge}
                           : {msum, acc[XLEN-1:1]};
    assign prod    = neg_q ? -acc_nxt : acc_nxt;
    assign q       = acc_nxt[XLEN-1:0];
    assign r       = acc_nxt[2*XLEN-1:XLEN];
    assign res     = ~f3[2] ? (f3[1:0] == 2'b00 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN])
                   : f3[1] ? (neg_r ? -r : r) : (neg_q ? -q : q);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = go ? (fast ? DONE : CALC) : IDLE;
            CALC:    state_nxt = cu2mdu_flush_i ? IDLE : (cnt == 1 ? DONE : CALC);
            default: state_nxt = IDLE;
        endcase
    end
    always_comb begin
        mdu2cu_stall_o   = (state == CALC) | ((state == IDLE) & go);
        mdu_busy_o       = state != IDLE;
        mdu2regs_wb_en_o = (state == DONE) & ~cu2mdu_flush_i;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt                <= '0;
            f3                 <= '0;
            op_b               <= '0;
            acc                <= '0;
            neg_q              <= 1'b0;
            neg_r              <= 1'b0;
            mdu2regs_rd_addr_o <= '0;
            mdu2regs_rd_data_o <= '0;
        end else if (state == IDLE && go) begin
            cnt                <= CW'(XLEN);
            f3                 <= idex2mdu_funct3_i;
            op_b               <= b_mag;
            acc                <= {{XLEN{1'b0}}, a_mag};
            neg_q              <= s1_sgn ^ s2_sgn;
            neg_r              <= s1_sgn;
            mdu2regs_rd_addr_o <= idex2mdu_rd_addr_i;
            if (fast) mdu2regs_rd_data_o <= fast_res;
        end else if (state == CALC) begin
            acc <= acc_nxt;
            cnt <= cnt - 1'b1;
            if (cnt == 1 && !cu2mdu_flush_i) mdu2regs_rd_data_o <= res;
        end
    end
endmodule
